seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider; the subtract-side counterpart of the combinational adder in the datapath.
- Computes quotient and remainder of A / B by repeated shift-and-subtract, one quotient bit per clock.
- Sits beside the ALU; the control unit stalls on BUSY and captures Q/R when DONE pulses.

Parameters:
n, 32, operand/result width in bits (n >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
START  input  1  request; sampled only in IDLE
A  input  n  dividend; sampled on accepted START edge
B  input  n  divisor; sampled on accepted START edge
BUSY  output  1  high while state != IDLE
DONE  output  1  one-cycle pulse; Q/R/DIV0 valid
Q  output  n  quotient (registered)
R  output  n  remainder (registered)
DIV0  output  1  last operation had B == 0 (registered)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk; it overrides all other inputs.
  - Reset values: state=IDLE, BUSY=0, DONE=0, Q=0, R=0, DIV0=0, iteration counter=0.
- States: IDLE, RUN, FINISH. Output encoding:
  - BUSY = (state != IDLE).
  - DONE = (state == FINISH).
- IDLE:
  - On an edge with START=1 and B!=0: latch dividend into the quotient shift register and B into the divisor register; clear the working remainder (n+1 bits); clear the counter; go to RUN.
  - On an edge with START=1 and B==0: Q<=all ones, R<=A, DIV0<=1; go to FINISH. No RUN cycles.
  - On an edge with START=0: stay in IDLE.
- RUN (one iteration per edge):
  - rem_s = {rem[n-1:0], quo[n-1]}; quo_s = {quo[n-2:0], 0}.
  - If rem_s >= divisor: rem <= rem_s - divisor, quo <= quo_s | 1. Otherwise rem <= rem_s, quo <= quo_s.
  - The comparison is unsigned at n+1 bits; nothing is truncated before the compare.
  - The counter increments each edge. On the n-th RUN edge (counter == n-1): Q<=final quo, R<=final rem[n-1:0], DIV0<=0; go to FINISH.
- FINISH: lasts exactly one cycle with DONE=1, then IDLE.
- Latency:
  - START accepted at edge 0, B!=0: DONE is high in the cycle following edge n+1 … correction below.
  - Exact timing: RUN occupies the cycles after edges 0..n-1; FINISH (DONE=1) is the cycle after edge n.
  - Accept-to-DONE = n+1 cycles. For B==0 it is 1 cycle.
  - Back-to-back: START may be re-accepted on the edge that leaves FINISH? No. START is only sampled in IDLE, so the minimum issue interval is n+2 cycles.
- Boundary conditions:
  - START while BUSY is ignored; latched operands are unaffected; A and B may change freely after acceptance.
  - Q, R and DIV0 hold their last values in IDLE, RUN and FINISH until the next completion. They are not cleared on the next START.
  - A < B gives Q=0, R=A. A == B gives Q=1, R=0. A=0 gives Q=0, R=0. B=1 gives Q=A, R=0.
  - A=all ones and B=all ones gives Q=1, R=0. The (n+1)-bit remainder guarantees no overflow.
  - rst asserted mid-RUN or in FINISH: return to IDLE next edge with all outputs at reset values; the partial result is discarded; no DONE pulse.
  - rst and START on the same edge: reset wins; START is not accepted.
- Invariant: on every DONE with DIV0=0, Q*B + R == A and R < B.

Decomposition:
- Shared package div_pkg:
  - enum typedef div_state_t {IDLE, RUN, FINISH}.
  - Counter width function/constant: $clog2(n).
- One natural sub-module: div_step. It is combinational, computes one shift/compare/subtract iteration (rem, quo, divisor in; rem_next, quo_next out), and is instantiated once in RUN.
- Top-level module holds the FSM, counter and output registers.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with START=1 -> BUSY=0, DONE=0, Q=0, R=0, DIV0=0 throughout.
2. Basic, n=32: A=100, B=7, START pulsed one cycle -> BUSY high for 33 cycles, DONE pulses on cycle 33 after accept; Q=14, R=2, DIV0=0.
3. Extremes, n=32: A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF -> Q=1, R=0. Then A=5, B=9 -> Q=0, R=5.
4. Divide by zero: A=1234, B=0 -> DONE on the next cycle, Q=0xFFFFFFFF, R=1234, DIV0=1, no RUN cycles. A following A=10, B=3 -> Q=3, R=1, DIV0=0.
5. Ignore and abort: during RUN of A=50, B=5, pulse START with A=9, B=2 -> result is still Q=10, R=0. Restart; assert rst at RUN cycle 10 -> IDLE, outputs 0, no DONE.
6. Exhaustive at n=8: all 65536 (A,B) pairs, each START issued only when BUSY=0 -> every DONE satisfies the invariant. B=0 cases give Q=0xFF, R=A, DIV0=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } div_state_t;

   // Iteration counter width; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the remainder,
// then subtract the divisor if it fits.
module div_step #(
   parameter int unsigned Width = 32
) (
   input  logic [Width:0]   rem_i,
   input  logic [Width-1:0] quo_i,
   input  logic [Width-1:0] div_i,
   output logic [Width:0]   rem_o,
   output logic [Width-1:0] quo_o
);

   logic [Width:0] rem_s;
   logic           unused_rem_msb;

   // The working remainder stays below the divisor, so its top bit is always clear.
   assign unused_rem_msb = rem_i[Width];

   always_comb begin
      rem_s = {rem_i[Width-1:0], quo_i[Width-1]};
      rem_o = rem_s;
      quo_o = {quo_i[Width-2:0], 1'b0};
      if (rem_s >= {1'b0, div_i}) begin
         rem_o = rem_s - {1'b0, div_i};
         quo_o = {quo_i[Width-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, DONE pulses with
// registered Q/R/DIV0.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         START,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic         BUSY,
   output logic         DONE,
   output logic [n-1:0] Q,
   output logic [n-1:0] R,
   output logic         DIV0
);

   localparam int unsigned CntW = cnt_width(n);

   div_state_t      state_q;
   logic [CntW-1:0] cnt_q;
   logic [n:0]      rem_q;
   logic [n-1:0]    quo_q;
   logic [n-1:0]    div_q;
   logic [n-1:0]    q_q;
   logic [n-1:0]    r_q;
   logic            div0_q;

   logic [n:0]      rem_d;
   logic [n-1:0]    quo_d;

   div_step #(
      .Width (n)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         div0_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (START) begin
                  if (B != '0) begin
                     quo_q   <= A;
                     div_q   <= B;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= RUN;
                  end else begin
                     // Division by zero skips the iteration loop entirely.
                     q_q     <= '1;
                     r_q     <= A;
                     div0_q  <= 1'b1;
                     state_q <= FINISH;
                  end
               end
            end
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(n - 1)) begin
                  q_q     <= quo_d;
                  r_q     <= rem_d[n-1:0];
                  div0_q  <= 1'b0;
                  state_q <= FINISH;
               end
            end
            FINISH: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign BUSY = (state_q != IDLE);
   assign DONE = (state_q == FINISH);
   assign Q    = q_q;
   assign R    = r_q;
   assign DIV0 = div0_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, corner sequences and random
// operands against an arithmetic reference, at n=32 and n=8.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done, div0;
   logic [31:0] q, r;

   logic        start8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, div08;
   logic [7:0]  q8, r8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.n(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .START (start),
      .A     (a),
      .B     (b),
      .BUSY  (busy),
      .DONE  (done),
      .Q     (q),
      .R     (r),
      .DIV0  (div0)
   );

   seq_divider #(.n(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .START (start8),
      .A     (a8),
      .B     (b8),
      .BUSY  (busy8),
      .DONE  (done8),
      .Q     (q8),
      .R     (r8),
      .DIV0  (div08)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        d0;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for DONE on the 32-bit DUT; counts edges after accept and BUSY cycles.
   task automatic wait_done32(output int lat, output int busyc);
      lat = 0;
      busyc = 0;
      while (!done && lat < 40) begin
         if (busy) busyc++;
         step();
         lat++;
      end
      if (busy) busyc++;
      chk("done_seen", {31'b0, done}, 32'd1);
   endtask

   task automatic op32(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] eq,
                       input logic [31:0] er, input logic ed0);
      int lat, bc, elat;
      elat = (bb == 0) ? 0 : 32;
      a = aa;
      b = bb;
      start = 1'b1;
      step();
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      wait_done32(lat, bc);
      chk("q", q, eq);
      chk("r", r, er);
      chk("div0", {31'b0, div0}, {31'b0, ed0});
      chk("latency", lat, elat);
      chk("busy_cycles", bc, elat + 1);
      step();
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
   endtask

   task automatic op8(input logic [7:0] aa, input logic [7:0] bb);
      int lat;
      logic [7:0] eq, er;
      logic ed0;
      if (bb == 0) begin
         eq = 8'hFF; er = aa; ed0 = 1'b1;
      end else begin
         eq = aa / bb; er = aa % bb; ed0 = 1'b0;
      end
      a8 = aa;
      b8 = bb;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      lat = 0;
      while (!done8 && lat < 20) begin
         step();
         lat++;
      end
      chk("n8_done", {31'b0, done8}, 32'd1);
      chk("n8_q", {24'b0, q8}, {24'b0, eq});
      chk("n8_r", {24'b0, r8}, {24'b0, er});
      chk("n8_div0", {31'b0, div08}, {31'b0, ed0});
      step();
   endtask

   initial begin
      vec_t tbl[8];
      int lat, bc;
      logic [31:0] ra, rb;
      logic [7:0]  xa, xb;

      tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      tbl[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
      tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
      tbl[3] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
      tbl[4] = '{32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1};
      tbl[5] = '{32'd10, 32'd3, 32'd3, 32'd1, 1'b0};
      tbl[6] = '{32'd0, 32'd17, 32'd0, 32'd0, 1'b0};
      tbl[7] = '{32'd77, 32'd10, 32'd7, 32'd7, 1'b0};

      // Reset dominates a simultaneous START.
      rst = 1'b1;
      start = 1'b1;
      start8 = 1'b1;
      a = 32'd123;
      b = 32'd4;
      a8 = 8'd9;
      b8 = 8'd2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_busy", {31'b0, busy}, 32'd0);
         chk("rst_done", {31'b0, done}, 32'd0);
         chk("rst_q", q, 32'd0);
         chk("rst_r", r, 32'd0);
         chk("rst_div0", {31'b0, div0}, 32'd0);
         chk("rst_busy8", {31'b0, busy8}, 32'd0);
      end
      start = 1'b0;
      start8 = 1'b0;
      rst = 1'b0;
      step();

      foreach (tbl[i]) op32(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].d0);

      // START while busy is ignored; previous result holds during RUN.
      a = 32'd50;
      b = 32'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      a = 32'd9;
      b = 32'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("hold_q", q, 32'd7);
      chk("hold_r", r, 32'd7);
      a = $urandom;
      b = 32'd0;
      wait_done32(lat, bc);
      chk("ign_q", q, 32'd10);
      chk("ign_r", r, 32'd0);
      chk("ign_div0", {31'b0, div0}, 32'd0);
      step();

      // Abort mid-RUN: no DONE afterwards, outputs back to reset values.
      a = 32'd50;
      b = 32'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_q", q, 32'd0);
      chk("abort_r", r, 32'd0);
      chk("abort_div0", {31'b0, div0}, 32'd0);
      for (int i = 0; i < 36; i++) begin
         chk("abort_no_done", {31'b0, done}, 32'd0);
         step();
      end

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) rb = 32'd0;
         if ($urandom_range(0, 15) == 0) rb = ra;
         if (rb == 0) op32(ra, rb, 32'hFFFFFFFF, ra, 1'b1);
         else op32(ra, rb, ra / rb, ra % rb, 1'b0);
      end

      for (int i = 0; i < 1500; i++) begin
         xa = 8'($urandom);
         xb = 8'($urandom);
         case ($urandom_range(0, 7))
            0: xb = 8'd0;
            1: xb = 8'd1;
            2: xb = xa;
            3: xa = 8'hFF;
            default: ;
         endcase
         op8(xa, xb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
